dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16x16-bit data memory.
- Port A is the pipeline MEM stage; port B is the loader/debug port.
- Grants one requester at a time and drives the memory's read_mem/write_mem/rw_address/write_data.
- Returns registered read data with a one-cycle ack.
- Port A has fixed priority; a starvation counter guarantees port B service.

Parameters:
- STARVE_LIMIT, 4: consecutive A grants while B is pending before B is forced to win (1..15).
- AW, 16: address width of requester and memory ports.
- DW, 16: data width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  port A request; held high with stable a_we/a_addr/a_wdata until a_ack
- a_we  in  1  1 = write, 0 = read
- a_addr  in  AW  port A word address
- a_wdata  in  DW  port A write data
- a_ack  out  1  one-cycle pulse: port A transaction complete
- a_rdata  out  DW  port A read data, valid when a_ack is high, held until next A ack
- a_err  out  1  address error, qualified by a_ack (optional feature)
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err: same as port A, for port B
- read_mem  out  1  to memory read_mem
- write_mem  out  1  to memory write_mem
- rw_address  out  AW  to memory rw_address
- write_data  out  DW  to memory write_data
- read_data  in  DW  from memory read_data (combinational read)
- busy  out  1  high in any state other than IDLE
- owner_b  out  1  1 when the current/last grant is B

Behaviour:
- Reset (asynchronous, rst high):
  - state = IDLE; all outputs 0 (acks, rdata, err, memory controls, address, wdata, busy, owner_b).
  - starvation counter = 0.
- States:
  - IDLE: sample requests at the clock edge.
    - Neither request -> stay in IDLE.
    - Only one request -> grant it.
    - Both requests -> grant A, unless starve_cnt >= STARVE_LIMIT, then grant B.
    - On grant: latch owner, we, addr and wdata into registers; go to ACCESS.
  - ACCESS (1 cycle):
    - Drive rw_address and write_data from the latched registers.
    - Write: write_mem=1, read_mem=0. Read: read_mem=1, write_mem=0.
    - At the clock edge, capture read_data into the owner's rdata (reads only); go to RESP.
  - RESP (1 cycle):
    - Owner's ack=1; memory controls are 0.
    - Next state is IDLE. The requester drops req in the cycle after ack; a req still high in IDLE is treated as a new request.
- Latency: req seen high at edge N -> ACCESS in cycle N+1 -> ack in cycle N+2. Throughput is one transaction per 3 cycles.
- Starvation counter (4 bits, saturating at 15):
  - Increments on an A grant while b_req=1.
  - Clears on any B grant, or when b_req=0 in IDLE.
- Memory controls are registered outputs, glitch-free. write_mem is high for exactly one cycle per write.
- rw_address is driven at full AW width; the memory decodes [3:0].
- rdata of the non-owning port is unchanged. A write leaves the owner's rdata unchanged.
- rst asserted mid-transaction:
  - Immediate return to IDLE; write_mem drops at once; no ack issued.
  - The requester must re-request after reset.
- A req dropped before ack is a protocol violation; the transaction still completes and acks.

Optional Feature:
- Macro: DMEM_ARB_ADDR_CHECK_EN.
- Defined:
  - In IDLE, a granted request with addr[AW-1:4] != 0 skips ACCESS and goes directly to RESP.
  - No memory strobe; ack with err=1 and rdata=0.
  - Latency is 1 cycle shorter (ack at N+1).
  - Starvation accounting is unchanged.
- Undefined:
  - a_err/b_err tied to 0.
  - All addresses go to memory unchanged; the memory aliases on [3:0].

Test Plan:
- Single read: after reset, memory word 5 preloaded 0x1234; A read addr 0x0005 -> read_mem high 1 cycle with rw_address=0x0005; a_ack at req+2 with a_rdata=0x1234; b_ack stays 0.
- Single write then read: B writes 0xBEEF to addr 3 -> write_mem high exactly 1 cycle with write_data=0xBEEF; a following B read of addr 3 -> b_rdata=0xBEEF.
- Simultaneous requests: a_req and b_req held continuously, STARVE_LIMIT=4 -> grant order A,A,A,A,B,A,A,A,A,B; each transaction takes 3 cycles.
- Reset mid-write: assert rst during ACCESS of a write -> write_mem=0, busy=0, no ack, same cycle; after release, IDLE with all outputs 0.
- Back-to-back single port: A issues 3 reads to addrs 0,1,2 (req re-raised each time) -> three acks spaced 3 cycles apart with the correct data; owner_b=0 throughout.
- DMEM_ARB_ADDR_CHECK_EN defined: A read addr 0x0013 -> no read_mem/write_mem; a_ack at req+1 with a_err=1, a_rdata=0. Macro undefined: same access reads word 3, a_err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the 16x16 data memory
// Optional address range check enabled by defining DMEM_ARB_ADDR_CHECK_EN.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 16,
    parameter int DW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    output logic          a_err,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          b_err,
    output logic          read_mem,
    output logic          write_mem,
    output logic [AW-1:0] rw_address,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data,
    output logic          busy,
    output logic          owner_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t        state;
    state_t        state_next;
    logic [3:0]    starve_cnt;
    logic [3:0]    starve_next;
    logic          grant;
    logic          grant_b;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          addr_bad;
    logic          we_q;

    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;
    assign busy      = (state != IDLE);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    assign addr_bad = |sel_addr[AW-1:4];
`else
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // A wins ties unless B has already lost STARVE_LIMIT times in a row.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_b     = 1'b0;
        starve_next = starve_cnt;
        case (state)
            IDLE: begin
                grant   = a_req | b_req;
                grant_b = b_req & (~a_req | (starve_cnt >= STARVE_LIM));
                if (!b_req || grant_b) begin
                    starve_next = '0;
                end else if (starve_cnt != 4'hF) begin
                    starve_next = starve_cnt + 4'd1;
                end
                if (grant) begin
                    state_next = addr_bad ? RESP : ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            read_mem   <= 1'b0;
            write_mem  <= 1'b0;
            rw_address <= '0;
            write_data <= '0;
            owner_b    <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            read_mem  <= 1'b0;
            write_mem <= 1'b0;
            if (grant) begin
                owner_b    <= grant_b;
                we_q       <= sel_we;
                rw_address <= sel_addr;
                write_data <= sel_wdata;
                if (addr_bad) begin
                    if (grant_b) begin
                        b_ack   <= 1'b1;
                        b_rdata <= '0;
                    end else begin
                        a_ack   <= 1'b1;
                        a_rdata <= '0;
                    end
                end else begin
                    read_mem  <= ~sel_we;
                    write_mem <= sel_we;
                end
            end
            if (state == ACCESS) begin
                if (owner_b) begin
                    b_ack <= 1'b1;
                    if (!we_q) b_rdata <= read_data;
                end else begin
                    a_ack <= 1'b1;
                    if (!we_q) a_rdata <= read_data;
                end
            end
        end
    end

`ifdef DMEM_ARB_ADDR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_err <= 1'b0;
            b_err <= 1'b0;
        end else if (grant && addr_bad) begin
            if (grant_b) b_err <= 1'b1;
            else         a_err <= 1'b1;
        end else if (state == ACCESS) begin
            if (owner_b) b_err <= 1'b0;
            else         a_err <= 1'b0;
        end
    end
`else
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with transaction-level model
module tb_dmem_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [15:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic        a_ack, a_err, b_ack, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic        read_mem, write_mem, busy, owner_b;
    logic [15:0] rw_address, write_data, read_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .read_mem(read_mem), .write_mem(write_mem), .rw_address(rw_address),
        .write_data(write_data), .read_data(read_data),
        .busy(busy), .owner_b(owner_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory the DUT talks to
    logic [15:0] env_mem [16];
    assign read_data = env_mem[rw_address[3:0]];
    always @(posedge clk) if (write_mem) env_mem[rw_address[3:0]] <= write_data;

    // Model: a granted transaction occupies the edges g..g+2 (g..g+1 if rejected).
    logic [15:0] m_mem [16];
    int          e = 0, g = -100, free_at = 0, starve = 0;
    bit          m_owner = 0, m_we = 0, m_bad = 0, pick_b;
    logic [15:0] m_addr = 0, m_wdata = 0;
    logic [15:0] m_a_rdata = 0, m_b_rdata = 0;
    bit          m_a_err = 0, m_b_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; g = -100; free_at = 0; starve = 0;
            m_owner = 0; m_we = 0; m_bad = 0;
            m_a_rdata = 0; m_b_rdata = 0; m_a_err = 0; m_b_err = 0;
        end else begin
            e = e + 1;
            if (e == g + 1 && !m_bad) begin
                if (m_we) m_mem[m_addr[3:0]] = m_wdata;
                else if (m_owner) m_b_rdata = m_mem[m_addr[3:0]];
                else m_a_rdata = m_mem[m_addr[3:0]];
                if (m_owner) m_b_err = 0; else m_a_err = 0;
            end
            if (e >= free_at) begin
                if (!b_req) starve = 0;
                if (a_req || b_req) begin
                    pick_b = b_req && (!a_req || starve >= STARVE_LIMIT);
                    if (pick_b) starve = 0;
                    else if (b_req && starve < 15) starve = starve + 1;
                    g = e;
                    m_owner = pick_b;
                    m_we    = pick_b ? b_we : a_we;
                    m_addr  = pick_b ? b_addr : a_addr;
                    m_wdata = pick_b ? b_wdata : a_wdata;
`ifdef DMEM_ARB_ADDR_CHECK_EN
                    m_bad = (m_addr >> 4) != 0;
`else
                    m_bad = 0;
`endif
                    free_at = e + (m_bad ? 2 : 3);
                    if (m_bad) begin
                        if (pick_b) begin m_b_rdata = 0; m_b_err = 1; end
                        else begin m_a_rdata = 0; m_a_err = 1; end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit strobe, ack;
        strobe = (e == g) && !m_bad;
        ack    = m_bad ? (e == g) : (e == g + 1);
        chk("read_mem",  read_mem,  strobe && !m_we);
        chk("write_mem", write_mem, strobe && m_we);
        chk("a_ack",     a_ack,     ack && !m_owner);
        chk("b_ack",     b_ack,     ack && m_owner);
        chk("busy",      busy,      (e == g) || (!m_bad && e == g + 1));
        chk("owner_b",   owner_b,   m_owner);
        chk("a_rdata",   a_rdata,   m_a_rdata);
        chk("b_rdata",   b_rdata,   m_b_rdata);
        chk("a_err",     a_err,     m_a_err);
        chk("b_err",     b_err,     m_b_err);
        if (strobe) chk("rw_address", rw_address, m_addr);
        if (strobe && m_we) chk("write_data", write_data, m_wdata);
    end

    // Issue one request from a negedge; returns data, ack latency and ack cycle.
    task automatic do_req(input bit pb, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, output logic [15:0] rd,
                          output int lat, output bit err, output int at);
        bit got = 0;
        lat = 0; rd = 0; err = 0; at = 0;
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (pb ? b_ack : a_ack) begin
                got = 1; lat = i; at = cyc;
                rd  = pb ? b_rdata : a_rdata;
                err = pb ? b_err : a_err;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(negedge clk);
        if (pb) b_req = 0; else a_req = 0;
    endtask

    initial begin
        logic [15:0] rd;
        int lat, at, prev_at, first_at, nacks;
        bit err;
        logic [9:0] order;

        for (int i = 0; i < 16; i++) begin
            env_mem[i] = 16'h0100 + 16'(i);
            m_mem[i]   = 16'h0100 + 16'(i);
        end
        env_mem[5] = 16'h1234;
        m_mem[5]   = 16'h1234;

        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_read_mem", read_mem, 0);
        chk("rst_rw_address", rw_address, 0);

        do_req(0, 0, 16'h0005, 0, rd, lat, err, at);
        chk("rd5_lat", lat, 2);
        chk("rd5_data", rd, 16'h1234);

        do_req(1, 1, 16'h0003, 16'hBEEF, rd, lat, err, at);
        chk("wr3_lat", lat, 2);
        do_req(1, 0, 16'h0003, 0, rd, lat, err, at);
        chk("rd3_data", rd, 16'hBEEF);

        // Both ports held continuously
        a_req = 1; a_we = 0; a_addr = 16'h0001;
        b_req = 1; b_we = 0; b_addr = 16'h0002;
        order = 0; nacks = 0; first_at = 0; prev_at = 0;
        for (int i = 0; i < 60 && nacks < 10; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                order = {order[8:0], b_ack};
                if (nacks == 0) first_at = cyc;
                else chk("both_spacing", cyc - prev_at, 3);
                prev_at = cyc;
                nacks++;
            end
        end
        a_req = 0; b_req = 0;
        chk("both_count", nacks, 10);
        chk("both_order", order, 10'b0000100001);
        chk("both_span", prev_at - first_at, 27);
        repeat (2) @(negedge clk);

        // Reset during the ACCESS cycle of a write
        a_req = 1; a_we = 1; a_addr = 16'h0007; a_wdata = 16'h5555;
        @(posedge clk);
        #2;
        chk("mid_wr_strobe", write_mem, 1);
        rst = 1;
        #1;
        chk("mid_rst_write_mem", write_mem, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_a_ack", a_ack, 0);
        a_req = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ack", a_ack, 0);
        chk("post_rst_addr", rw_address, 0);
        do_req(0, 0, 16'h0007, 0, rd, lat, err, at);
        chk("aborted_wr7", rd, 16'h0107);

        // Back-to-back A reads
        for (int i = 0; i < 3; i++) begin
            do_req(0, 0, 16'(i), 0, rd, lat, err, at);
            chk("b2b_data", rd, 16'h0100 + 16'(i));
            if (i > 0) chk("b2b_spacing", at - prev_at, 3);
            prev_at = at;
        end

        do_req(0, 0, 16'h0013, 0, rd, lat, err, at);
`ifdef DMEM_ARB_ADDR_CHECK_EN
        chk("oob_lat", lat, 1);
        chk("oob_err", err, 1);
        chk("oob_data", rd, 16'h0000);
`else
        chk("alias_lat", lat, 2);
        chk("alias_err", err, 0);
        chk("alias_data", rd, 16'hBEEF);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
